// File: rtl/game_ctrl.sv
// Snake game controller: button synchronise/debounce, PLAY/PAUSE/IDLE/OVER sequencing,
// level-scaled step pulse generation.
module game_ctrl #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned STEP_BASE = 25_000_000,
    parameter int unsigned STEP_DEC  = 2_000_000,
    parameter int unsigned STEP_MIN  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       hit_wall,
    input  logic       hit_self,
    input  logic       get_food,
    output logic [1:0] game_state,
    output logic       step,
    output logic [3:0] level
);

    localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam int SW = 32;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        PAUSE = 2'b01,
        IDLE  = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t state_q, state_d;

    // Bit 0 is the start button, bit 1 the pause button.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          db_q, db_d;
    logic [1:0]          db_prev_q, db_prev_d;
    logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic [3:0]          level_q, level_d;

    logic          start_p;
    logic          pause_p;
    logic          collide;
    logic [SW-1:0] dec_amt;
    logic [SW-1:0] period;
    logic          step_hit;

    always_comb begin
        sync1_d   = {btn_pause, btn_start};
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        db_cnt_d  = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    assign start_p = db_q[0] & ~db_prev_q[0];
    assign pause_p = db_q[1] & ~db_prev_q[1];
    assign collide = hit_wall | hit_self;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_p) state_d = PLAY;
            PLAY: begin
                if (collide)      state_d = OVER;
                else if (pause_p) state_d = PAUSE;
            end
            PAUSE:   if (start_p || pause_p) state_d = PLAY;
            OVER:    if (start_p) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Compare before subtracting so the period never underflows at high levels.
    always_comb begin
        dec_amt = SW'(level_q) * SW'(STEP_DEC);
        if (dec_amt >= SW'(STEP_BASE - STEP_MIN)) begin
            period = SW'(STEP_MIN);
        end else begin
            period = SW'(STEP_BASE) - dec_amt;
        end
    end

    // >= rather than == so a shortened period after a level-up fires at once.
    assign step_hit = (state_q == PLAY) && (step_cnt_q >= period - SW'(1));

    always_comb begin
        case (state_q)
            PLAY:    step_cnt_d = step_hit ? '0 : step_cnt_q + SW'(1);
            PAUSE:   step_cnt_d = step_cnt_q;
            default: step_cnt_d = '0;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if ((state_q == PLAY) && get_food && (level_q != 4'hF)) begin
            level_d = level_q + 4'd1;
        end
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            level_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            db_cnt_q   <= '0;
            step_cnt_q <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            db_prev_q  <= db_prev_d;
            db_cnt_q   <= db_cnt_d;
            step_cnt_q <= step_cnt_d;
            level_q    <= level_d;
        end
    end

    assign game_state = state_q;
    assign step       = step_hit;
    assign level      = level_q;

endmodule
